conv_tile_loader: RTL and testbench

Stream-to-tile loader that sits directly upstream of the convolution engine. It accepts a byte stream carrying kernel and image bytes, assembles a 20×6 input tile and a 3×3 kernel in registers, and fires the engine's `start`. It then holds both arrays stable until the engine reports completion, and only after that re-opens the stream for the next tile.

---
 rtl/conv_pkg.sv | 16 +
 rtl/rowmajor_ctr.sv | 34 +++
 rtl/conv_tile_loader.sv | 98 +++++++++
 tb/tb_conv_tile_loader.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/conv_pkg.sv
// Shared definitions for the convolution engine and the tile loader that feeds it.
package conv_pkg;
  localparam int TILE_R = 20;
  localparam int TILE_C = 6;
  localparam int K      = 3;
  localparam int DW     = 8;

  typedef logic [TILE_R-1:0][TILE_C-1:0][DW-1:0] tile_t;
  typedef logic [K-1:0][K-1:0][DW-1:0]           kern_t;

  typedef enum logic [1:0] {
    LOAD = 2'd0,
    FIRE = 2'd1,
    BUSY = 2'd2
  } loader_state_e;
endpackage

// File: rtl/rowmajor_ctr.sv
// Row-major (row, col) position counter; wrap pulses on the enabled step that leaves the last cell.
module rowmajor_ctr #(
  parameter int ROWS = 3,
  parameter int COLS = 3,
  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1,
  localparam int CW = (COLS > 1) ? $clog2(COLS) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  output logic [RW-1:0] row,
  output logic [CW-1:0] col,
  output logic          wrap
);
  logic last_col, last_row;

  assign last_col = (col == CW'(COLS-1));
  assign last_row = (row == RW'(ROWS-1));
  assign wrap     = en & last_col & last_row;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row <= '0;
      col <= '0;
    end else if (en) begin
      if (last_col) begin
        col <= '0;
        row <= last_row ? '0 : row + RW'(1);
      end else begin
        col <= col + CW'(1);
      end
    end
  end
endmodule

// File: rtl/conv_tile_loader.sv
// Assembles a tile and a kernel from a byte stream, fires the engine, and holds both
// arrays frozen until the engine signals completion.
module conv_tile_loader #(
  parameter int TILE_R = conv_pkg::TILE_R,
  parameter int TILE_C = conv_pkg::TILE_C,
  parameter int K      = conv_pkg::K,
  parameter int DW     = conv_pkg::DW
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               s_valid,
  output logic                               s_ready,
  input  logic [DW-1:0]                      s_data,
  input  logic                               s_kern,
  output logic [TILE_R-1:0][TILE_C-1:0][DW-1:0] tile,
  output logic [K-1:0][K-1:0][DW-1:0]        kernel,
  output logic                               conv_start,
  input  logic                               conv_done,
  output logic                               busy,
  output logic [15:0]                        tile_cnt
);
  import conv_pkg::*;

  localparam int TRW = (TILE_R > 1) ? $clog2(TILE_R) : 1;
  localparam int TCW = (TILE_C > 1) ? $clog2(TILE_C) : 1;
  localparam int KW  = (K > 1) ? $clog2(K) : 1;

  loader_state_e state, nxt;

  logic           tile_full, kern_valid, done_q;
  logic           k_acc, t_acc, k_wrap, t_wrap;
  logic           fire_ok, done_rise;
  logic [TRW-1:0] tr;
  logic [TCW-1:0] tc;
  logic [KW-1:0]  kr, kc;

  assign k_acc = s_valid & s_ready & s_kern;
  assign t_acc = s_valid & s_ready & ~s_kern;

  rowmajor_ctr #(.ROWS(TILE_R), .COLS(TILE_C)) u_tile_ctr (
    .clk(clk), .rst_n(rst_n), .en(t_acc), .row(tr), .col(tc), .wrap(t_wrap)
  );

  rowmajor_ctr #(.ROWS(K), .COLS(K)) u_kern_ctr (
    .clk(clk), .rst_n(rst_n), .en(k_acc), .row(kr), .col(kc), .wrap(k_wrap)
  );

  // A kernel reload in progress (counters off origin) must block firing.
  assign fire_ok   = tile_full & kern_valid & (kr == '0) & (kc == '0);
  assign done_rise = (state == BUSY) & conv_done & ~done_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= LOAD;
    else        state <= nxt;
  end

  always_comb begin
    nxt = state;
    case (state)
      LOAD:    if (fire_ok) nxt = FIRE;
      FIRE:    nxt = BUSY;
      BUSY:    if (done_rise) nxt = LOAD;
      default: nxt = LOAD;
    endcase
  end

  always_comb begin
    conv_start = 1'b0;
    busy       = 1'b0;
    s_ready    = 1'b0;
    case (state)
      LOAD:    s_ready = s_kern | ~tile_full;
      FIRE:    begin conv_start = 1'b1; busy = 1'b1; end
      BUSY:    busy = 1'b1;
      default: ;
    endcase
  end

  // done_q tracks conv_done every cycle so a level already high at BUSY entry is not an edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tile       <= '0;
      kernel     <= '0;
      tile_full  <= 1'b0;
      kern_valid <= 1'b0;
      done_q     <= 1'b0;
      tile_cnt   <= '0;
    end else begin
      done_q <= conv_done;
      if (k_acc)  kernel[kr][kc] <= s_data;
      if (t_acc)  tile[tr][tc]   <= s_data;
      if (k_wrap) kern_valid     <= 1'b1;
      if (t_wrap)         tile_full <= 1'b1;
      else if (done_rise) tile_full <= 1'b0;
      if (done_rise) tile_cnt <= tile_cnt + 16'd1;
    end
  end
endmodule

// File: tb/tb_conv_tile_loader.sv
// Scenario table, hand-built corner sequences and random traffic, all checked every cycle
// against a flat-array model of the loader.
module tb_conv_tile_loader;
  localparam int TR = 20, TC = 6, K = 3, DW = 8;
  localparam int NT = TR*TC, NK = K*K;

  logic clk = 1'b0, rst_n = 1'b0;
  logic s_valid = 1'b0, s_kern = 1'b0, conv_done = 1'b0;
  logic [DW-1:0] s_data = '0;
  logic s_ready, conv_start, busy;
  logic [15:0] tile_cnt;
  logic [TR-1:0][TC-1:0][DW-1:0] tile;
  logic [K-1:0][K-1:0][DW-1:0]   kernel;

  always #5 clk = ~clk;

  conv_tile_loader dut (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .s_kern(s_kern), .tile(tile), .kernel(kernel), .conv_start(conv_start),
    .conv_done(conv_done), .busy(busy), .tile_cnt(tile_cnt)
  );

  int nvec = 0, nmiss = 0, n_starts = 0;

  // Model: byte arrays indexed by arrival position, plus phase 0=loading, 1=start, 2=engine running.
  byte unsigned mt[NT];
  byte unsigned mk[NK];
  int tidx, kidx, ph;
  bit tfull, kvalid, dprev, cd;
  int unsigned mcnt;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nmiss++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk_arrays();
    logic [TR-1:0][TC-1:0][DW-1:0] et;
    logic [K-1:0][K-1:0][DW-1:0]   ek;
    for (int i = 0; i < NT; i++) et[i/TC][i%TC] = mt[i];
    for (int i = 0; i < NK; i++) ek[i/K][i%K] = mk[i];
    nvec++;
    if (tile !== et) begin
      nmiss++;
      for (int i = NT-1; i >= 0; i--)
        if (tile[i/TC][i%TC] !== et[i/TC][i%TC])
          $display("FAIL tile[%0d][%0d]: got %0h want %0h at %0t", i/TC, i%TC,
                   tile[i/TC][i%TC], et[i/TC][i%TC], $time);
    end
    nvec++;
    if (kernel !== ek) begin
      nmiss++;
      $display("FAIL kernel: got %0h want %0h at %0t", kernel, ek, $time);
    end
  endtask

  function automatic void m_reset();
    foreach (mt[i]) mt[i] = 0;
    foreach (mk[i]) mk[i] = 0;
    tidx = 0; kidx = 0; ph = 0; tfull = 0; kvalid = 0; dprev = 0; mcnt = 0;
  endfunction

  // Called just after a negedge; returns just after the following negedge.
  task automatic step(input bit v, input bit k, input logic [7:0] d, output bit acc);
    bit rdy, cond, rise;
    s_valid = v; s_kern = k; s_data = d; conv_done = cd;
    #1;
    rdy = (ph == 0) && (k || !tfull);
    chk("s_ready", 32'(s_ready), 32'(rdy));
    acc  = v && rdy;
    cond = (ph == 0) && tfull && kvalid && (kidx == 0);
    rise = (ph == 2) && cd && !dprev;
    @(posedge clk);
    if (acc && k) begin
      mk[kidx] = d;
      kidx = (kidx + 1) % NK;
      if (kidx == 0) kvalid = 1;
    end else if (acc) begin
      mt[tidx] = d;
      tidx = (tidx + 1) % NT;
      if (tidx == 0) tfull = 1;
    end
    case (ph)
      0: if (cond) ph = 1;
      1: ph = 2;
      default: if (rise) begin ph = 0; tfull = 0; mcnt = (mcnt + 1) % 65536; end
    endcase
    dprev = cd;
    #1;
    if (conv_start === 1'b1) n_starts++;
    chk("conv_start", 32'(conv_start), 32'(ph == 1));
    chk("busy", 32'(busy), 32'(ph != 0));
    chk("tile_cnt", 32'(tile_cnt), mcnt);
    chk_arrays();
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    bit a;
    repeat (n) step(1'b0, 1'b0, 8'h00, a);
  endtask

  task automatic send(input bit k, input logic [7:0] d);
    bit a = 0;
    int n = 0;
    while (!a && n < 200) begin step(1'b1, k, d, a); n++; end
    if (!a) begin
      nvec++; nmiss++;
      $display("FAIL send_timeout: got no accept want accept within 200 cycles at %0t", $time);
    end
  endtask

  task automatic pulse_done();
    bit a;
    cd = 1; step(1'b0, 1'b0, 8'h00, a);
    cd = 0; idle(2);
  endtask

  task automatic do_reset();
    s_valid = 0; s_kern = 0; cd = 0; conv_done = 0;
    rst_n = 0;
    #1;
    m_reset();
    chk("rst_conv_start", 32'(conv_start), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_tile_cnt", 32'(tile_cnt), 32'd0);
    chk("rst_s_ready", 32'(s_ready), 32'd1);
    chk_arrays();
    @(negedge clk);
    rst_n = 1;
  endtask

  typedef struct {
    bit rst;
    bit kfirst;
    int nk;
    int nt;
    int extra;
    int exp_starts;
    int exp_cnt;
  } scen_t;

  scen_t scen[5];

  initial begin
    bit a;
    scen[0] = '{rst:1, kfirst:1, nk:9, nt:120, extra:0, exp_starts:1, exp_cnt:1};
    scen[1] = '{rst:0, kfirst:1, nk:0, nt:120, extra:0, exp_starts:1, exp_cnt:2};
    scen[2] = '{rst:1, kfirst:0, nk:9, nt:120, extra:3, exp_starts:1, exp_cnt:1};
    scen[3] = '{rst:0, kfirst:1, nk:4, nt:120, extra:0, exp_starts:0, exp_cnt:1};
    scen[4] = '{rst:0, kfirst:1, nk:5, nt:0,   extra:0, exp_starts:1, exp_cnt:2};

    m_reset();
    @(negedge clk);

    foreach (scen[r]) begin
      if (scen[r].rst) do_reset();
      n_starts = 0;
      if (scen[r].kfirst) for (int i = 0; i < scen[r].nk; i++) send(1'b1, 8'(i + 1 + 16*r));
      for (int i = 0; i < scen[r].nt; i++) send(1'b0, 8'(i + r));
      for (int i = 0; i < scen[r].extra; i++) step(1'b1, 1'b0, 8'hEE, a);
      if (!scen[r].kfirst) for (int i = 0; i < scen[r].nk; i++) send(1'b1, 8'(i + 1 + 16*r));
      idle(4);
      if (r == 0) begin
        chk("kernel22", 32'(kernel[2][2]), 32'd9);
        chk("tile19_5", 32'(tile[19][5]), 32'd119);
      end
      pulse_done();
      chk($sformatf("scen%0d_starts", r), n_starts, scen[r].exp_starts);
      chk($sformatf("scen%0d_cnt", r), 32'(tile_cnt), scen[r].exp_cnt);
    end

    // conv_done held high across BUSY entry must not complete the tile.
    do_reset();
    for (int i = 0; i < NK; i++) send(1'b1, 8'(i + 1));
    cd = 1;
    for (int i = 0; i < NT; i++) send(1'b0, 8'(i));
    idle(6);
    chk("held_busy", 32'(busy), 32'd1);
    chk("held_cnt", 32'(tile_cnt), 32'd0);
    cd = 0; idle(2);
    pulse_done();
    chk("held_then_pulse_cnt", 32'(tile_cnt), 32'd1);
    n_starts = 0;
    for (int i = 0; i < NT; i++) send(1'b0, 8'(255 - i));
    idle(4);
    pulse_done();
    chk("second_tile_starts", n_starts, 32'd1);
    chk("second_tile_cnt", 32'(tile_cnt), 32'd2);

    // Reset in the middle of a tile discards everything, then a fresh load fires.
    do_reset();
    for (int i = 0; i < NK; i++) send(1'b1, 8'(i + 40));
    for (int i = 0; i < 60; i++) send(1'b0, 8'(i + 3));
    do_reset();
    n_starts = 0;
    for (int i = 0; i < NK; i++) send(1'b1, 8'(i + 70));
    for (int i = 0; i < NT; i++) send(1'b0, 8'(i * 3));
    idle(4);
    pulse_done();
    chk("post_reset_starts", n_starts, 32'd1);
    chk("post_reset_cnt", 32'(tile_cnt), 32'd1);

    // Random interleaved traffic with random engine completion.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) do_reset();
      cd = ($urandom_range(0, 4) == 0);
      step($urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0, 8'($urandom), a);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmiss);
    $finish;
  end
endmodule
